ttt_token_tx: RTL and testbench
===============================

TTT_TOKEN_TX -- requirements
Module: ttt_token_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, token-request FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TICK_PERIOD, default 16, cycles per tick (>=4).
REQ-003 SHALL have parameter GAP, default 1, minimum low cycles between consecutive strobes (>=1).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port ena, input, 1, transmit enable.
REQ-007 SHALL have port in_valid, input, 1, request valid.
REQ-008 SHALL have port in_ready, output, 1, request accepted when high with in_valid.
REQ-009 SHALL have port in_id, input, 4, target token id.
REQ-010 SHALL have port in_count, input, 4, number of tokens to send.
REQ-011 SHALL have port tok_strobe, output, 1, one-cycle token pulse to the tick-tock-tokens input pins.
REQ-012 SHALL have port tok_id, output, 4, token id, valid while tok_strobe high.
REQ-013 SHALL have port tok_tick, output, 1, one-cycle tick pulse.
REQ-014 SHALL have port busy, output, 1, FIFO non-empty or FSM not IDLE.
REQ-015 SHALL have port sent_cnt, output, 8, total strobes issued.

Function
REQ-016 SHALL assert in_ready combinationally as NOT FIFO full; push on in_valid AND in_ready.
REQ-017 SHALL accept requests with in_count=0 and discard them (no push, no pin activity).
REQ-018 SHALL run an internal tick counter 0..TICK_PERIOD-1 while ena=1, freezing while ena=0; tok_tick is registered, high exactly in cycles where the counter equals TICK_PERIOD-1.
REQ-019 SHALL implement FSM states IDLE, SEND, GAP.
REQ-020 IDLE: if FIFO non-empty, pop into cur_id/remaining (remaining=count) and go SEND; else stay.
REQ-021 SHALL drive tok_strobe in a SEND cycle only if ena=1 and tok_tick is not high in that cycle; otherwise stay in SEND with no strobe (strobe deferred, never dropped).
REQ-022 On a strobe: decrement remaining; go GAP (load GAP counter); from GAP return to SEND after GAP low cycles if remaining>0, else IDLE.
REQ-023 SHALL register tok_strobe/tok_id; tok_id=cur_id while strobing, 4'h0 otherwise.
REQ-024 Latency: request pushed into empty FIFO at edge N -> popped at edge N+1 -> first tok_strobe high in cycle after edge N+2 (absent tick/ena stall).
REQ-025 Strobe spacing for one request SHALL be exactly GAP+1 cycles unless deferred by tick or ena.
REQ-026 Simultaneous push and pop SHALL both occur; a push on a full FIFO SHALL not occur (in_ready low).
REQ-027 sent_cnt SHALL increment once per strobe and wrap 255->0.
REQ-028 Deasserting ena SHALL not affect FIFO acceptance; FSM state and remaining are held.

Reset
REQ-029 rst_n low SHALL asynchronously clear FIFO pointers, FSM to IDLE, tick/GAP counters, remaining, sent_cnt; tok_strobe, tok_id, tok_tick, busy = 0.
REQ-030 Reset mid-transmission SHALL abandon all pending tokens; in_ready SHALL be 1 in the first cycle after release.

Structure
REQ-031 Package ttt_pkg SHALL hold the FSM state enum, token_req_t struct {id[3:0], count[3:0]}, and parameter defaults.
REQ-032 The FIFO SHALL be sub-module ttt_token_fifo (synchronous, registered storage, full/empty flags, same clk/rst_n).

Verification
REQ-033 Single request id=5, count=3, defaults -> three strobes with tok_id=5 spaced 2 cycles, first strobe at edge N+2, sent_cnt=3, busy falls after.
REQ-034 Five back-to-back requests with pins stalled by ena=0 -> in_ready low after 4 accepted; fifth accepted once ena=1 and one entry pops; order preserved.
REQ-035 Strobe scheduled in the tick cycle (counter=15) -> no strobe that cycle, strobe next cycle, token count unchanged.
REQ-036 Request count=0 -> accepted, no strobe, sent_cnt unchanged.
REQ-037 rst_n pulsed low during request count=15 after 4 strobes -> outputs 0 immediately, no further strobes, in_ready=1 after release.
REQ-038 Issue 260 tokens -> sent_cnt=4 (wrap verified).

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared types and parameter defaults for the tick-tock-tokens transmitter.
// Holds the FSM state encoding and the request record carried through the FIFO.
package ttt_pkg;

  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_TICK_PERIOD = 16;
  localparam int DEF_GAP         = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic [3:0] id;
    logic [3:0] count;
  } token_req_t;

endpackage

// File: rtl/ttt_token_fifo.sv
// Token-request FIFO: registered storage, wrap-bit pointers, full/empty flags.
// Latency: pushed entry visible on pop_dat the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty.
module ttt_token_fifo
  import ttt_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  token_req_t push_dat,
  input  logic       pop,
  output token_req_t pop_dat,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  token_req_t     mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/ttt_token_tx.sv
// Token transmitter: queues (id, count) requests and emits spaced one-cycle strobes plus a periodic tick.
// Latency: push at edge N, pop at N+1, first strobe registered at N+2.
// Backpressure: in_ready = FIFO not full; ena low freezes tick, FSM and pops but not acceptance.
module ttt_token_tx
  import ttt_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int TICK_PERIOD = DEF_TICK_PERIOD,
  parameter int GAP         = DEF_GAP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_id,
  input  logic [3:0] in_count,
  output logic       tok_strobe,
  output logic [3:0] tok_id,
  output logic       tok_tick,
  output logic       busy,
  output logic [7:0] sent_cnt
);

  localparam logic [1:0] ST_IDLE = 2'(S_IDLE);
  localparam logic [1:0] ST_SEND = 2'(S_SEND);
  localparam logic [1:0] ST_GAP  = 2'(S_GAP);

  localparam int            TW        = $clog2(TICK_PERIOD);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_PERIOD - 1);
  localparam int            GW        = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP - 1);

  logic [1:0]    state;
  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] tick_next;
  logic          tick_hit_next;
  logic [GW-1:0] gap_cnt;
  logic [3:0]    remaining;
  logic [3:0]    cur_id;
  logic          fire;

  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  token_req_t    push_req;
  token_req_t    head_req;

  // Zero-count requests complete the handshake but never enter the FIFO.
  assign in_ready   = !fifo_full;
  assign fifo_push  = in_valid && !fifo_full && (in_count != 4'h0);
  assign fifo_pop   = ena && (state == ST_IDLE) && !fifo_empty;
  assign push_req   = '{id: in_id, count: in_count};
  assign busy       = !fifo_empty || (state != ST_IDLE);

  ttt_token_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_dat (push_req),
    .pop      (fifo_pop),
    .pop_dat  (head_req),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    tick_next = tick_cnt;
    if (ena) tick_next = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
  end

  // A strobe that would land in a tick cycle is held back one cycle.
  assign tick_hit_next = (tick_next == TICK_LAST);
  assign fire          = ena && (state == ST_SEND) && !tick_hit_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt   <= '0;
      tok_tick   <= 1'b0;
      tok_strobe <= 1'b0;
      tok_id     <= 4'h0;
      sent_cnt   <= 8'h00;
    end else begin
      tick_cnt   <= tick_next;
      tok_tick   <= tick_hit_next;
      tok_strobe <= fire;
      tok_id     <= fire ? cur_id : 4'h0;
      if (fire) sent_cnt <= sent_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gap_cnt   <= '0;
      remaining <= 4'h0;
      cur_id    <= 4'h0;
    end else if (ena) begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cur_id    <= head_req.id;
            remaining <= head_req.count;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (fire) begin
            remaining <= remaining - 4'd1;
            gap_cnt   <= GAP_LOAD;
            state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) state <= (remaining != 4'h0) ? ST_SEND : ST_IDLE;
          else               gap_cnt <= gap_cnt - GW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_token_tx.sv
// Self-checking bench for ttt_token_tx: directed scenarios plus a randomized scoreboard run.
// Expected token order and tick timing come from request lists and cycle arithmetic.
module tb_ttt_token_tx;

  localparam int P = 16;
  localparam int G = 1;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_id = 4'h0;
  logic [3:0] in_count = 4'h0;
  logic       tok_strobe;
  logic [3:0] tok_id;
  logic       tok_tick;
  logic       busy;
  logic [7:0] sent_cnt;

  always #5 clk = ~clk;

  ttt_token_tx #(
    .FIFO_DEPTH  (D),
    .TICK_PERIOD (P),
    .GAP         (G)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_id      (in_id),
    .in_count   (in_count),
    .tok_strobe (tok_strobe),
    .tok_id     (tok_id),
    .tok_tick   (tok_tick),
    .busy       (busy),
    .sent_cnt   (sent_cnt)
  );

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         exp_sent = 0;
  int         s_cyc[$];
  logic [3:0] s_id[$];
  logic [3:0] exp_q[$];

  // One clock: observe outputs on the falling edge and log any strobe.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (tok_strobe === 1'b1) begin
      s_cyc.push_back(cyc);
      s_id.push_back(tok_id);
    end
  endtask

  task automatic clear_logs();
    s_cyc.delete();
    s_id.delete();
    exp_q.delete();
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * P; i++) begin
      step();
      if (tok_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (busy === 1'b0 && tok_strobe === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) step();
  endtask

  task automatic push_req(input logic [3:0] id, input logic [3:0] cnt, output bit ok);
    in_id    = id;
    in_count = cnt;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (in_ready === 1'b1) begin
        step();
        ok = 1'b1;
        break;
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena   = 1'b0;
    repeat (3) step();
    checks++; if (tok_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", tok_strobe); end
    checks++; if (tok_id !== 4'h0) begin errors++; $display("FAIL reset_id: got %h want 0", tok_id); end
    checks++; if (tok_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", tok_tick); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (sent_cnt !== 8'h00) begin errors++; $display("FAIL reset_sent: got %0d want 0", sent_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    rst_n    = 1'b1;
    exp_sent = 0;
  endtask

  task automatic test_single();
    bit ok;
    int k;
    ena = 1'b1;
    wait_tick(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_sync: no tick seen, got 0 want 1"); end
    clear_logs();
    push_req(4'h5, 4'd3, ok);
    k = cyc;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    wait_idle(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_idle: busy never fell, got 0 want 1"); end
    checks++; if (s_id.size() != 3) begin errors++; $display("FAIL single_count: got %0d want 3", s_id.size()); end
    if (s_id.size() == 3) begin
      checks++; if (s_cyc[0] != k + 2) begin errors++; $display("FAIL single_latency: got %0d want %0d", s_cyc[0] - k, 2); end
      checks++; if (s_cyc[1] - s_cyc[0] != G + 1 || s_cyc[2] - s_cyc[1] != G + 1) begin
        errors++; $display("FAIL single_spacing: got %0d,%0d want %0d", s_cyc[1] - s_cyc[0], s_cyc[2] - s_cyc[1], G + 1);
      end
      checks++; if (s_id[0] !== 4'h5 || s_id[1] !== 4'h5 || s_id[2] !== 4'h5) begin
        errors++; $display("FAIL single_id: got %h %h %h want 5", s_id[0], s_id[1], s_id[2]);
      end
    end
    exp_sent += 3;
    checks++; if (sent_cnt !== 8'(exp_sent)) begin errors++; $display("FAIL single_sent: got %0d want %0d", sent_cnt, 8'(exp_sent)); end
  endtask

  task automatic test_tick_defer();
    bit         ok;
    int         t;
    logic [3:0] id;
    ena = 1'b1;
    id  = 4'($urandom_range(1, 15));
    wait_tick(ok);
    t = cyc;
    checks++; if (!ok) begin errors++; $display("FAIL tick_sync: no tick seen, got 0 want 1"); end
    clear_logs();
    repeat (13) step();
    push_req(id, 4'd1, ok);
    step();
    step();
    checks++; if (cyc != t + P) begin errors++; $display("FAIL tick_align: got %0d want %0d", cyc - t, P); end
    checks++; if (tok_tick !== 1'b1 || tok_strobe !== 1'b0) begin
      errors++; $display("FAIL tick_cycle: got tick=%b strobe=%b want tick=1 strobe=0", tok_tick, tok_strobe);
    end
    step();
    checks++; if (tok_strobe !== 1'b1 || tok_id !== id || tok_tick !== 1'b0) begin
      errors++; $display("FAIL tick_deferred: got strobe=%b id=%h tick=%b want 1 %h 0", tok_strobe, tok_id, tok_tick, id);
    end
    wait_idle(40, ok);
    checks++; if (s_id.size() != 1) begin errors++; $display("FAIL tick_tokens: got %0d want 1", s_id.size()); end
    exp_sent += 1;
    checks++; if (sent_cnt !== 8'(exp_sent)) begin errors++; $display("FAIL tick_sent: got %0d want %0d", sent_cnt, 8'(exp_sent)); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int rdy_bad = 0;
    int ord_bad = 0;
    clear_logs();
    ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_id    = 4'($urandom_range(0, 15));
      in_count = 4'($urandom_range(1, 3));
      in_valid = 1'b1;
      if (in_ready !== 1'b1) rdy_bad++;
      for (int j = 0; j < int'(in_count); j++) exp_q.push_back(in_id);
      step();
    end
    checks++; if (rdy_bad != 0) begin errors++; $display("FAIL b2b_accept4: got %0d refusals want 0", rdy_bad); end
    in_id    = 4'($urandom_range(0, 15));
    in_count = 4'($urandom_range(1, 3));
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got ready=%b want 0", in_ready); end
    repeat (3) step();
    checks++; if (in_ready !== 1'b0 || s_id.size() != 0) begin
      errors++; $display("FAIL b2b_stall: got ready=%b strobes=%0d want 0 0", in_ready, s_id.size());
    end
    ena = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_pop_frees: got ready=%b want 1", in_ready); end
    for (int j = 0; j < int'(in_count); j++) exp_q.push_back(in_id);
    step();
    in_valid = 1'b0;
    wait_idle(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_idle: busy never fell, got 0 want 1"); end
    checks++; if (s_id.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", s_id.size(), exp_q.size()); end
    for (int i = 0; i < s_id.size() && i < exp_q.size(); i++) if (s_id[i] !== exp_q[i]) ord_bad++;
    checks++; if (ord_bad != 0) begin errors++; $display("FAIL b2b_order: got %0d id mismatches want 0", ord_bad); end
    exp_sent += exp_q.size();
    checks++; if (sent_cnt !== 8'(exp_sent)) begin errors++; $display("FAIL b2b_sent: got %0d want %0d", sent_cnt, 8'(exp_sent)); end
  endtask

  task automatic test_zero_count();
    clear_logs();
    ena      = 1'b1;
    in_id    = 4'($urandom_range(0, 15));
    in_count = 4'd0;
    in_valid = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", busy); end
    repeat (10) step();
    checks++; if (s_id.size() != 0) begin errors++; $display("FAIL zero_strobes: got %0d want 0", s_id.size()); end
    checks++; if (sent_cnt !== 8'(exp_sent)) begin errors++; $display("FAIL zero_sent: got %0d want %0d", sent_cnt, 8'(exp_sent)); end
  endtask

  task automatic test_random();
    bit   ok;
    int   m;
    int   tick_bad = 0;
    int   ovl_bad = 0;
    int   ena_bad = 0;
    int   gap_bad = 0;
    int   ord_bad = 0;
    logic e_now;
    logic acc;
    ena = 1'b1;
    wait_tick(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rand_sync: no tick seen, got 0 want 1"); end
    m = P - 1;
    clear_logs();
    for (int i = 0; i < 600; i++) begin
      ena      = ($urandom_range(0, 4) != 0);
      in_valid = $urandom_range(0, 1);
      in_id    = 4'($urandom_range(0, 15));
      in_count = 4'($urandom_range(0, 6));
      e_now    = ena;
      acc      = in_valid && (in_ready === 1'b1);
      if (acc) for (int j = 0; j < int'(in_count); j++) exp_q.push_back(in_id);
      step();
      if (e_now) m = (m + 1) % P;
      if (tok_tick !== (m == P - 1)) tick_bad++;
      if (tok_strobe === 1'b1 && tok_tick === 1'b1) ovl_bad++;
      if (tok_strobe === 1'b1 && !e_now) ena_bad++;
    end
    in_valid = 1'b0;
    ena      = 1'b1;
    wait_idle(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rand_idle: busy never fell, got 0 want 1"); end
    checks++; if (tick_bad != 0) begin errors++; $display("FAIL rand_tick: got %0d wrong tick cycles want 0", tick_bad); end
    checks++; if (ovl_bad != 0) begin errors++; $display("FAIL rand_overlap: got %0d strobe-on-tick want 0", ovl_bad); end
    checks++; if (ena_bad != 0) begin errors++; $display("FAIL rand_ena: got %0d strobes while disabled want 0", ena_bad); end
    for (int i = 1; i < s_cyc.size(); i++) if (s_cyc[i] - s_cyc[i-1] < G + 1) gap_bad++;
    checks++; if (gap_bad != 0) begin errors++; $display("FAIL rand_gap: got %0d short gaps want 0", gap_bad); end
    checks++; if (s_id.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", s_id.size(), exp_q.size()); end
    for (int i = 0; i < s_id.size() && i < exp_q.size(); i++) if (s_id[i] !== exp_q[i]) ord_bad++;
    checks++; if (ord_bad != 0) begin errors++; $display("FAIL rand_order: got %0d id mismatches want 0", ord_bad); end
    exp_sent += exp_q.size();
    checks++; if (sent_cnt !== 8'(exp_sent)) begin errors++; $display("FAIL rand_sent: got %0d want %0d", sent_cnt, 8'(exp_sent)); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit got4 = 1'b0;
    int n;
    clear_logs();
    ena = 1'b1;
    push_req(4'($urandom_range(0, 15)), 4'd15, ok);
    for (int i = 0; i < 100; i++) begin
      if (s_id.size() >= 4) begin
        got4 = 1'b1;
        break;
      end
      step();
    end
    checks++; if (!got4) begin errors++; $display("FAIL rmid_progress: got %0d strobes want 4", s_id.size()); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (tok_strobe !== 1'b0 || tok_id !== 4'h0 || tok_tick !== 1'b0) begin
      errors++; $display("FAIL rmid_async: got strobe=%b id=%h tick=%b want 0 0 0", tok_strobe, tok_id, tok_tick);
    end
    checks++; if (busy !== 1'b0 || sent_cnt !== 8'h00) begin
      errors++; $display("FAIL rmid_clear: got busy=%b sent=%0d want 0 0", busy, sent_cnt);
    end
    step();
    step();
    rst_n    = 1'b1;
    exp_sent = 0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", in_ready); end
    n = s_id.size();
    repeat (40) step();
    checks++; if (s_id.size() != n || busy !== 1'b0) begin
      errors++; $display("FAIL rmid_abandon: got %0d extra strobes busy=%b want 0 0", s_id.size() - n, busy);
    end
  endtask

  task automatic test_wrap();
    bit         ok;
    int         push_bad = 0;
    int         ord_bad = 0;
    logic [3:0] id;
    clear_logs();
    ena = 1'b1;
    for (int r = 0; r < 18; r++) begin
      id = 4'($urandom_range(0, 15));
      push_req(id, (r < 17) ? 4'd15 : 4'd5, ok);
      if (!ok) push_bad++;
      for (int j = 0; j < ((r < 17) ? 15 : 5); j++) exp_q.push_back(id);
    end
    wait_idle(600, ok);
    checks++; if (push_bad != 0 || !ok) begin errors++; $display("FAIL wrap_flow: got %0d stuck pushes idle=%b want 0 1", push_bad, ok); end
    checks++; if (s_id.size() != 260) begin errors++; $display("FAIL wrap_tokens: got %0d want 260", s_id.size()); end
    for (int i = 0; i < s_id.size() && i < exp_q.size(); i++) if (s_id[i] !== exp_q[i]) ord_bad++;
    checks++; if (ord_bad != 0) begin errors++; $display("FAIL wrap_order: got %0d id mismatches want 0", ord_bad); end
    exp_sent += 260;
    checks++; if (sent_cnt !== 8'd4 || sent_cnt !== 8'(exp_sent)) begin
      errors++; $display("FAIL wrap_sent: got %0d want %0d", sent_cnt, 8'(exp_sent));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tick_defer();
    test_back_to_back();
    test_zero_count();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
